// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage non-forwarding pipeline:
// per-register pending-write scoreboard, memory port arbitration and STOP drain.
module pipeline_hazard_ctrl #(
  parameter int NREG  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       id_instr,
  input  logic             id_valid,
  input  logic [7:0]       wb_instr,
  input  logic             wb_valid,
  input  logic             ex_mem_req,
  output logic             stall,
  output logic             bubble,
  output logic             fetch_en,
  output logic             mem_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int IDX_W = 2;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_NAND  = 4'b1000;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  function automatic logic has_dst(input logic [7:0] ins);
    case (ins[3:0])
      OP_LOAD, OP_ADD, OP_SUB, OP_NAND, OP_ORI: has_dst = 1'b1;
      default:                                  has_dst = 1'b0;
    endcase
  endfunction

  // ORI has an implicit k1 destination regardless of the ra field
  function automatic logic [IDX_W-1:0] dst_reg(input logic [7:0] ins);
    dst_reg = (ins[3:0] == OP_ORI) ? IDX_W'(1) : ins[7:6];
  endfunction

  function automatic logic [NREG-1:0] src_mask(input logic [7:0] ins);
    logic [NREG-1:0] m;
    m = '0;
    case (ins[3:0])
      OP_ADD, OP_SUB, OP_NAND, OP_STORE: begin
        m[ins[7:6]] = 1'b1;
        m[ins[5:4]] = 1'b1;
      end
      OP_LOAD: m[ins[5:4]] = 1'b1;
      OP_ORI:  m[1]        = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  state_t                     state, state_nx;
  logic [NREG-1:0][IDX_W-1:0] pend;
  logic [NREG-1:0]            busy;
  logic                       run, hazard, stall_raw, issue;
  logic                       inc_any, dec_any;
  logic [IDX_W-1:0]           inc_idx, dec_idx;

  assign run       = (state == RUN);
  assign hazard    = id_valid & |(src_mask(id_instr) & busy);
  assign stall_raw = hazard | ~run | ex_mem_req;
  assign issue     = run & id_valid & ~stall_raw;

  assign inc_any = issue & has_dst(id_instr);
  assign inc_idx = dst_reg(id_instr);
  assign dec_any = wb_valid & has_dst(wb_instr);
  assign dec_idx = dst_reg(wb_instr);

  // One pending-write counter per architectural register
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic inc, dec;
    assign inc     = inc_any & (inc_idx == IDX_W'(r));
    assign dec     = dec_any & (dec_idx == IDX_W'(r));
    assign busy[r] = |pend[r];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)           pend[r] <= '0;
      else if (inc && !dec) pend[r] <= pend[r] + 1'b1;
      else if (dec && !inc) pend[r] <= pend[r] - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (issue && id_instr[3:0] == OP_STOP) state_nx = DRAIN;
      DRAIN:   if (!(|busy) && !wb_valid)             state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  stall_cycles <= '0;
    else if (run && stall_raw && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end

  // Combinational controls are held low while reset is asserted
  assign stall    = reset & stall_raw;
  assign bubble   = reset & (hazard | ~run);
  assign fetch_en = reset & run & ~stall_raw;
  assign mem_sel  = reset & ex_mem_req;
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: stimulus pushes expected
// per-cycle responses, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;
  localparam int NREG  = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       id_instr = 8'h0A;
  logic             id_valid = 1'b0;
  logic [7:0]       wb_instr = 8'h0A;
  logic             wb_valid = 1'b0;
  logic             ex_mem_req = 1'b0;
  logic             stall, bubble, fetch_en, mem_sel, halted;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_instr(id_instr), .id_valid(id_valid),
    .wb_instr(wb_instr), .wb_valid(wb_valid),
    .ex_mem_req(ex_mem_req),
    .stall(stall), .bubble(bubble), .fetch_en(fetch_en), .mem_sel(mem_sel),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // flags = {stall, bubble, fetch_en, mem_sel, halted}
  localparam logic [4:0] F_ZERO  = 5'b00000;
  localparam logic [4:0] F_RUN   = 5'b00100;
  localparam logic [4:0] F_HZ    = 5'b11000;
  localparam logic [4:0] F_MEM   = 5'b10010;
  localparam logic [4:0] F_DRN   = 5'b11000;
  localparam logic [4:0] F_DRN_M = 5'b11010;
  localparam logic [4:0] F_HLT   = 5'b11001;

  typedef struct {
    string            name;
    logic [4:0]       flags;
    logic [CNT_W-1:0] sc;
    logic [7:0]       pend;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic vec(input string name, input logic rst,
                     input logic [7:0] ii, input logic iv,
                     input logic [7:0] wi, input logic wv, input logic er,
                     input logic [4:0] fl, input int sc, input logic [7:0] pd);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; id_instr = ii; id_valid = iv;
    wb_instr = wi; wb_valid = wv; ex_mem_req = er;
    e.name = name; e.flags = fl; e.sc = CNT_W'(sc); e.pend = pd;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t       e;
    logic [4:0] gf;
    logic [7:0] gp;
    if (q.size() > 0) begin
      e  = q.pop_front();
      gf = {stall, bubble, fetch_en, mem_sel, halted};
      gp = dut.pend;
      total++;
      if (gf !== e.flags || stall_cycles !== e.sc || gp !== e.pend) begin
        bad++;
        $display("FAIL %s: got flags=%b sc=%0d pend=%h, want flags=%b sc=%0d pend=%h",
                 e.name, gf, stall_cycles, gp, e.flags, e.sc, e.pend);
      end
    end
    for (int r = 0; r < NREG; r++)
      if (dut.pend[r] == 2'd3) begin
        bad++;
        $display("FAIL pend_range: k%0d count=3 want <=2", r);
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec("reset_hold0", 0, 8'h64, 1, 8'h64, 1, 1, F_ZERO, 0, 8'h00);
    vec("reset_hold1", 0, 8'h64, 1, 8'h64, 1, 1, F_ZERO, 0, 8'h00);
    // independent stream, then distance-2 dependence (1 stall)
    vec("indep_64",    1, 8'h64, 1, 8'h00, 0, 0, F_RUN, 0, 8'h00);
    vec("indep_B0",    1, 8'hB0, 1, 8'h00, 0, 0, F_RUN, 0, 8'h04);
    vec("dist2_stall", 1, 8'h14, 1, 8'h64, 1, 0, F_HZ,  0, 8'h14);
    vec("dist2_issue", 1, 8'h14, 1, 8'hB0, 1, 0, F_RUN, 1, 8'h10);
    // back-to-back dependence (2 stalls)
    vec("b2b_prod",    1, 8'h64, 1, 8'h00, 0, 0, F_RUN, 1, 8'h01);
    vec("b2b_stall1",  1, 8'h14, 1, 8'h14, 1, 0, F_HZ,  1, 8'h05);
    vec("b2b_stall2",  1, 8'h14, 1, 8'h64, 1, 0, F_HZ,  2, 8'h04);
    vec("b2b_issue",   1, 8'h14, 1, 8'h00, 0, 0, F_RUN, 3, 8'h00);
    // EX memory request takes the port
    vec("ex_mem",      1, 8'hB0, 1, 8'h00, 0, 1, F_MEM, 3, 8'h01);
    vec("ex_mem_done", 1, 8'hB0, 1, 8'h14, 1, 0, F_RUN, 4, 8'h01);
    // same-cycle commit and issue of a k2 writer
    vec("k0_writer",   1, 8'h30, 1, 8'h00, 0, 0, F_RUN, 4, 8'h10);
    vec("same_cyc_k2", 1, 8'hB0, 1, 8'hB0, 1, 0, F_RUN, 4, 8'h11);
    vec("k2_unchanged",1, 8'h0A, 0, 8'h30, 1, 0, F_RUN, 4, 8'h11);
    vec("idle_commit", 1, 8'h0A, 0, 8'hB0, 1, 0, F_RUN, 4, 8'h10);
    // STOP drain and halt
    vec("pre_stop",    1, 8'h64, 1, 8'h00, 0, 0, F_RUN, 4, 8'h00);
    vec("stop_issue",  1, 8'h01, 1, 8'h00, 0, 0, F_RUN, 4, 8'h04);
    vec("drain_wb",    1, 8'h0A, 0, 8'h64, 1, 0, F_DRN, 4, 8'h04);
    vec("drain_empty", 1, 8'h0A, 0, 8'h00, 0, 0, F_DRN, 4, 8'h00);
    for (int i = 0; i < 10; i++)
      vec("halt_hold", 1, 8'h64, 1, 8'h00, 0, 0, F_HLT, 4, 8'h00);
    vec("reset_halt",  0, 8'h64, 1, 8'h00, 0, 1, F_ZERO, 0, 8'h00);
    // reset in the middle of a drain with a pending write
    vec("post_reset",  1, 8'h64, 1, 8'h00, 0, 0, F_RUN,   0, 8'h00);
    vec("stop2",       1, 8'h01, 1, 8'h00, 0, 0, F_RUN,   0, 8'h04);
    vec("drain_exreq", 1, 8'h0A, 0, 8'h00, 0, 1, F_DRN_M, 0, 8'h04);
    vec("reset_drain", 0, 8'h14, 1, 8'h64, 1, 1, F_ZERO,  0, 8'h00);
    vec("release_run", 1, 8'h0A, 0, 8'h00, 0, 0, F_RUN,   0, 8'h00);
    // stall counter saturation
    for (int i = 0; i < 9; i++)
      vec("sat", 1, 8'h0A, 0, 8'h00, 0, 1, F_MEM, (i > 7) ? 7 : i, 8'h00);
    vec("sat_hold",    1, 8'h0A, 0, 8'h00, 0, 0, F_RUN, 7, 8'h00);

    repeat (4) @(posedge clock);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
